// File: rtl/vt100_key_encoder.sv
// Keyboard-event to VT100 byte-stream encoder: queues key events in a small FIFO and
// expands special keys into ESC sequences, feeding a UART transmitter one byte at a time.
module vt100_key_encoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               keyValid,
    input  logic               keyIsSpecial,
    input  logic [7:0]         keyData,
    input  logic               appCursorMode,
    input  logic               txBusy,
    output logic               txStart,
    output logic [7:0]         txData,
    output logic               keyDropped,
    output logic [FIFO_AW:0]   fifoCount,
    output logic               active,
    output logic [2:0]         fsmState
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SEND    = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4
    } state_t;

    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);

    state_t               state_q;
    logic [8:0]           mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]     count_q, count_d;
    logic [8:0]           ent_q;
    logic [31:0]          seq_q;
    logic [2:0]           len_q;
    logic                 txStart_q, keyDropped_q;
    logic [7:0]           txData_q;

    logic                 full, empty, push, pop;
    logic [31:0]          dec_seq;
    logic [2:0]           dec_len;
    logic                 dec_ok;
    logic [7:0]           dec_br;

    // Fullness is judged on the registered count, so a same-cycle pop never rescues a push.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign push  = keyValid && !full;
    assign pop   = (state_q == S_IDLE) && !empty;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {keyIsSpecial, keyData};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Cursor keys switch '[' to 'O' in application cursor mode; the ~ keys never do.
    always_comb begin
        dec_br  = appCursorMode ? 8'h4F : 8'h5B;
        dec_seq = '0;
        dec_len = 3'd0;
        dec_ok  = 1'b1;
        if (!ent_q[8]) begin
            dec_seq = {ent_q[7:0], 24'h0};
            dec_len = 3'd1;
        end else begin
            case (ent_q[7:0])
                8'h01: begin dec_seq = {8'h1B, dec_br, 8'h41, 8'h00}; dec_len = 3'd3; end
                8'h02: begin dec_seq = {8'h1B, dec_br, 8'h42, 8'h00}; dec_len = 3'd3; end
                8'h03: begin dec_seq = {8'h1B, dec_br, 8'h43, 8'h00}; dec_len = 3'd3; end
                8'h04: begin dec_seq = {8'h1B, dec_br, 8'h44, 8'h00}; dec_len = 3'd3; end
                8'h05: begin dec_seq = {8'h1B, dec_br, 8'h48, 8'h00}; dec_len = 3'd3; end
                8'h06: begin dec_seq = {8'h1B, dec_br, 8'h46, 8'h00}; dec_len = 3'd3; end
                8'h07: begin dec_seq = {8'h1B, 8'h5B, 8'h32, 8'h7E}; dec_len = 3'd4; end
                8'h08: begin dec_seq = {8'h1B, 8'h5B, 8'h33, 8'h7E}; dec_len = 3'd4; end
                8'h09: begin dec_seq = {8'h1B, 8'h5B, 8'h35, 8'h7E}; dec_len = 3'd4; end
                8'h0A: begin dec_seq = {8'h1B, 8'h5B, 8'h36, 8'h7E}; dec_len = 3'd4; end
                default: dec_ok = 1'b0;
            endcase
        end
    end

    // Handshake: txStart is a one-cycle strobe issued only when txBusy was low at that edge;
    // the transmitter raises txBusy one cycle later, so WAIT_HI skips that cycle blindly
    // and WAIT_LO waits for busy to drop before the next byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ent_q        <= '0;
            seq_q        <= '0;
            len_q        <= '0;
            txStart_q    <= 1'b0;
            txData_q     <= '0;
            keyDropped_q <= 1'b0;
        end else begin
            txStart_q    <= 1'b0;
            keyDropped_q <= keyValid && full;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        ent_q   <= mem_q[rd_ptr_q];
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (dec_ok) begin
                        seq_q   <= dec_seq;
                        len_q   <= dec_len;
                        state_q <= S_SEND;
                    end else begin
                        keyDropped_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                S_SEND: begin
                    if (!txBusy) begin
                        txStart_q <= 1'b1;
                        txData_q  <= seq_q[31:24];
                        seq_q     <= {seq_q[23:0], 8'h00};
                        len_q     <= len_q - 3'd1;
                        state_q   <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: state_q <= S_WAIT_LO;
                S_WAIT_LO: begin
                    if (!txBusy) state_q <= (len_q != 3'd0) ? S_SEND : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign txStart    = txStart_q;
    assign txData     = txData_q;
    assign keyDropped = keyDropped_q;
    assign fifoCount  = count_q;
    assign active     = (state_q != S_IDLE) || !empty;
    assign fsmState   = state_q;

endmodule
